// File: rtl/svo_dec.sv
// Video stream decoder: drops blanking, forwards active pixels and measures frame geometry.
// Latency: 1 cycle from accepted non-blank beat to out_axis_tvalid when the buffer is empty.
// Backpressure: in_axis_tready = (fill < 3), from registers only; the 4-deep buffer absorbs the sink stall.
// Ports:
//   clk, resetn                     - clock, async active-low reset
//   in_axis_t{valid,ready,data,user} - encoded beats, tuser = {blank, vsync, hsync, sof}
//   out_axis_t{valid,ready,data,user} - active pixels, tuser = first pixel of frame
//   active_width/active_height      - last measured pixels per line / lines per frame
//   frame_valid, line_err           - geometry consistent flag, line-width mismatch pulse
module svo_dec #(
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int SVO_XYBITS         = 14
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic [3:0]                    in_axis_tuser,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic                          out_axis_tuser,
  output logic [SVO_XYBITS-1:0]         active_width,
  output logic [SVO_XYBITS-1:0]         active_height,
  output logic                          frame_valid,
  output logic                          line_err
);

  typedef enum logic {SEARCH = 1'b0, ACTIVE = 1'b1} state_t;

  localparam int                    ENTRY_W = SVO_BITS_PER_PIXEL + 1;
  localparam logic [SVO_XYBITS-1:0] CNT_MAX = '1;
  localparam logic [SVO_XYBITS-1:0] CNT_ONE = 1;

  state_t                  state;
  logic [ENTRY_W-1:0]      mem [4];
  logic [1:0]              wr_ptr;
  logic [1:0]              rd_ptr;
  logic [2:0]              fill;
  logic                    rdy_en;
  logic                    sof_pend;
  logic                    err_seen;
  logic [SVO_XYBITS-1:0]   wcnt;
  logic [SVO_XYBITS-1:0]   hcnt;

  logic accept;
  logic in_sof;
  logic in_blank;
  logic proc;
  logic push;
  logic pop;
  logic sync_unused;

  function automatic logic [SVO_XYBITS-1:0] sat_inc(input logic [SVO_XYBITS-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // hsync/vsync carry no information the decoder needs; blank and sof suffice.
  assign sync_unused = ^in_axis_tuser[2:1];

  // rdy_en holds ready low during reset and releases it on the first edge afterwards.
  assign in_axis_tready  = rdy_en && (fill < 3'd3);
  assign accept          = in_axis_tvalid && in_axis_tready;
  assign in_sof          = in_axis_tuser[0];
  assign in_blank        = in_axis_tuser[3];
  // A SOF beat seen while searching is handled as an active beat in the same cycle.
  assign proc            = accept && ((state == ACTIVE) || in_sof);
  assign push            = proc && !in_blank;

  assign out_axis_tvalid = (fill != 3'd0);
  assign pop             = out_axis_tvalid && out_axis_tready;
  assign out_axis_tdata  = mem[rd_ptr][SVO_BITS_PER_PIXEL-1:0];
  assign out_axis_tuser  = mem[rd_ptr][SVO_BITS_PER_PIXEL];

  // Pixel buffer. Fill never exceeds 3 because pushes require ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= {in_sof | sof_pend, in_axis_tdata};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      fill <= fill + 3'd1;
      else if (pop && !push) fill <= fill - 3'd1;
    end
  end

  // Frame tracking and geometry measurement.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= SEARCH;
      sof_pend      <= 1'b0;
      err_seen      <= 1'b0;
      wcnt          <= '0;
      hcnt          <= '0;
      active_width  <= '0;
      active_height <= '0;
      frame_valid   <= 1'b0;
      line_err      <= 1'b0;
    end else begin
      line_err <= 1'b0;
      if (proc) begin
        if (in_sof) begin
          // Only a SOF that closes a tracked frame carries a measurement.
          if (state == ACTIVE) begin
            active_height <= hcnt;
            frame_valid   <= !err_seen && (hcnt != '0);
          end
          state    <= ACTIVE;
          hcnt     <= '0;
          err_seen <= 1'b0;
          // A non-blank SOF beat is also the first pixel of line one.
          wcnt     <= in_blank ? '0 : CNT_ONE;
          sof_pend <= in_blank;
        end else if (!in_blank) begin
          wcnt     <= sat_inc(wcnt);
          sof_pend <= 1'b0;
        end else if (wcnt != '0) begin
          // First blank after a run of pixels closes the line.
          active_width <= wcnt;
          hcnt         <= sat_inc(hcnt);
          wcnt         <= '0;
          if ((hcnt != '0) && (wcnt != active_width)) begin
            line_err    <= 1'b1;
            frame_valid <= 1'b0;
            err_seen    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_svo_dec.sv
module tb_svo_dec;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [23:0] in_data = '0;
  logic [3:0]  in_user = '0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [23:0] out_data;
  logic        out_user;
  logic [13:0] aw;
  logic [13:0] ah;
  logic        fv;
  logic        lerr;

  int n_checks = 0;
  int n_fail = 0;
  int rdy_mode = 0;   // 0 ready, 1 stalled, 2 random
  int err_total = 0;
  int pix = 1;
  bit m_active = 1'b0;
  bit m_sofpend = 1'b0;
  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];

  svo_dec dut (
    .clk             (clk),
    .resetn          (resetn),
    .in_axis_tvalid  (in_vld),
    .in_axis_tready  (in_rdy),
    .in_axis_tdata   (in_data),
    .in_axis_tuser   (in_user),
    .out_axis_tvalid (out_vld),
    .out_axis_tready (out_rdy),
    .out_axis_tdata  (out_data),
    .out_axis_tuser  (out_user),
    .active_width    (aw),
    .active_height   (ah),
    .frame_valid     (fv),
    .line_err        (lerr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_rdy = 1'b1;
      1: out_rdy = 1'b0;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (resetn && out_vld && out_rdy) got_q.push_back({out_user, out_data});
    if (lerr) err_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Drive one beat and wait for acceptance; updates the expected-pixel model.
  task automatic send_beat(input logic [23:0] d, input logic [3:0] u);
    int t;
    in_data = d;
    in_user = u;
    in_vld  = 1'b1;
    t = 0;
    while (!in_rdy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept timeout got in_rdy=%b want 1", in_rdy);
    end else begin
      if (u[0]) begin m_active = 1'b1; m_sofpend = 1'b1; end
      if (m_active && !u[3]) begin exp_q.push_back({m_sofpend, d}); m_sofpend = 1'b0; end
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  // h lines of w pixels (last line last_w), 2 blank beats per line, one blank line.
  task automatic send_frame(input int w, input int h, input int last_w, input int gap);
    int lw;
    for (int l = 0; l < h; l++) begin
      lw = (l == h - 1) ? last_w : w;
      for (int x = 0; x < lw; x++) begin
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        send_beat(24'(pix), (l == 0 && x == 0) ? 4'b0001 : 4'b0000);
        pix++;
      end
      for (int b = 0; b < 2; b++) begin
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        send_beat(24'hB00000, 4'b1010);
      end
    end
    for (int b = 0; b < w + 2; b++) begin
      repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      send_beat(24'hC00000, 4'b1100);
    end
  endtask

  task automatic drain(output bit ok);
    int t;
    t = 0;
    while (out_vld === 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (out_vld === 1'b0);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #1;
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy got %b want 0", in_rdy); end
    n_checks++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (out_user !== 1'b0) begin n_fail++; $display("FAIL reset_out_user got %b want 0", out_user); end
    n_checks++; if (aw !== 14'd0 || ah !== 14'd0) begin n_fail++; $display("FAIL reset_geom got %0d/%0d want 0/0", aw, ah); end
    n_checks++; if (fv !== 1'b0 || lerr !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", fv, lerr); end
    @(posedge clk); #3;
    resetn = 1'b1;
    #1;
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_before_edge got %b want 0", in_rdy); end
    @(posedge clk); #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_after_edge got %b want 1", in_rdy); end
  endtask

  task automatic test_midframe;
    int eb, gb;
    bit ok;
    eb = exp_q.size(); gb = got_q.size();
    for (int i = 0; i < 5; i++) send_beat(24'h700000 + 24'(i), 4'b0000);
    drain(ok);
    n_checks++; if (got_q.size() - gb !== 0) begin n_fail++; $display("FAIL midframe_pre_sof got %0d pixels want 0", got_q.size() - gb); end
    send_frame(4, 2, 4, 0);
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midframe_drain got out_vld=%b want 0", out_vld); end
    n_checks++;
    if (got_q.size() - gb !== 8) begin n_fail++; $display("FAIL midframe_count got %0d want 8", got_q.size() - gb); end
    else begin
      n_checks++; if (got_q[gb][24] !== 1'b1) begin n_fail++; $display("FAIL midframe_first_sof got %b want 1", got_q[gb][24]); end
      for (int i = 0; i < exp_q.size() - eb; i++) begin
        n_checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin n_fail++; $display("FAIL midframe_pix%0d got %h want %h", i, got_q[gb+i], exp_q[eb+i]); end
      end
    end
  endtask

  task automatic test_basic_frame;
    int eb, gb, e0, sofs;
    bit ok;
    eb = exp_q.size(); gb = got_q.size(); e0 = err_total;
    send_frame(4, 2, 4, 0);
    send_frame(4, 2, 4, 0);
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_drain got out_vld=%b want 0", out_vld); end
    n_checks++;
    if (got_q.size() - gb !== 16) begin n_fail++; $display("FAIL basic_count got %0d want 16", got_q.size() - gb); end
    else begin
      for (int i = 0; i < exp_q.size() - eb; i++) begin
        n_checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin n_fail++; $display("FAIL basic_pix%0d got %h want %h", i, got_q[gb+i], exp_q[eb+i]); end
      end
    end
    sofs = 0;
    for (int i = gb; i < got_q.size(); i++) sofs += int'(got_q[i][24]);
    n_checks++; if (sofs !== 2) begin n_fail++; $display("FAIL basic_sof_count got %0d want 2", sofs); end
    n_checks++; if (aw !== 14'd4) begin n_fail++; $display("FAIL basic_width got %0d want 4", aw); end
    n_checks++; if (ah !== 14'd2) begin n_fail++; $display("FAIL basic_height got %0d want 2", ah); end
    n_checks++; if (fv !== 1'b1) begin n_fail++; $display("FAIL basic_frame_valid got %b want 1", fv); end
    n_checks++; if (err_total - e0 !== 0) begin n_fail++; $display("FAIL basic_line_err got %0d pulses want 0", err_total - e0); end
  endtask

  task automatic test_backpressure;
    int eb, gb;
    bit ok;
    eb = exp_q.size(); gb = got_q.size();
    rdy_mode = 1;
    fork
      send_frame(4, 2, 4, 0);
      begin
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_rdy got %b want 0", in_rdy); end
        n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL bp_out_vld got %b want 1", out_vld); end
        n_checks++; if (got_q.size() - gb !== 0) begin n_fail++; $display("FAIL bp_no_pop got %0d want 0", got_q.size() - gb); end
        rdy_mode = 0;
      end
    join
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_drain got out_vld=%b want 0", out_vld); end
    n_checks++;
    if (got_q.size() - gb !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", got_q.size() - gb); end
    else begin
      for (int i = 0; i < exp_q.size() - eb; i++) begin
        n_checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin n_fail++; $display("FAIL bp_pix%0d got %h want %h", i, got_q[gb+i], exp_q[eb+i]); end
      end
    end
  endtask

  task automatic test_line_err;
    int e0;
    e0 = err_total;
    send_frame(4, 2, 4, 0);
    send_frame(4, 2, 3, 0);
    n_checks++; if (err_total - e0 !== 1) begin n_fail++; $display("FAIL lerr_pulse got %0d cycles want 1", err_total - e0); end
    n_checks++; if (fv !== 1'b0) begin n_fail++; $display("FAIL lerr_fv_cleared got %b want 0", fv); end
    send_frame(4, 2, 4, 0);
    n_checks++; if (fv !== 1'b0) begin n_fail++; $display("FAIL lerr_fv_next_sof got %b want 0", fv); end
    n_checks++; if (ah !== 14'd2) begin n_fail++; $display("FAIL lerr_height got %0d want 2", ah); end
    send_frame(4, 2, 4, 0);
    n_checks++; if (fv !== 1'b1) begin n_fail++; $display("FAIL lerr_fv_recover got %b want 1", fv); end
    n_checks++; if (err_total - e0 !== 1) begin n_fail++; $display("FAIL lerr_total got %0d want 1", err_total - e0); end
  endtask

  task automatic test_async_reset;
    int eb, gb;
    bit ok;
    eb = exp_q.size(); gb = got_q.size();
    rdy_mode = 1;
    send_beat(24'(pix), 4'b0001); pix++;
    send_beat(24'(pix), 4'b0000); pix++;
    n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL ar_pre_out_vld got %b want 1", out_vld); end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL ar_out_vld got %b want 0", out_vld); end
    n_checks++; if (out_data !== 24'h0 || out_user !== 1'b0) begin n_fail++; $display("FAIL ar_out_dat got %b/%h want 0/0", out_user, out_data); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL ar_in_rdy got %b want 0", in_rdy); end
    n_checks++; if (fv !== 1'b0 || aw !== 14'd0 || ah !== 14'd0) begin n_fail++; $display("FAIL ar_geom got %b/%0d/%0d want 0/0/0", fv, aw, ah); end
    m_active = 1'b0; m_sofpend = 1'b0;
    while (exp_q.size() > eb) void'(exp_q.pop_back());
    @(posedge clk); #3;
    resetn = 1'b1;
    #1;
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL ar_rdy_before_edge got %b want 0", in_rdy); end
    @(posedge clk); #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL ar_rdy_after_edge got %b want 1", in_rdy); end
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) begin send_beat(24'(pix), 4'b0000); pix++; end
    send_beat(24'hB00000, 4'b1010);
    send_beat(24'hB00000, 4'b1010);
    drain(ok);
    n_checks++; if (got_q.size() - gb !== 0) begin n_fail++; $display("FAIL ar_no_output got %0d want 0", got_q.size() - gb); end
    send_frame(4, 2, 4, 0);
    drain(ok);
    n_checks++;
    if (got_q.size() - gb !== 8) begin n_fail++; $display("FAIL ar_count got %0d want 8", got_q.size() - gb); end
    else begin
      for (int i = 0; i < exp_q.size() - eb; i++) begin
        n_checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin n_fail++; $display("FAIL ar_pix%0d got %h want %h", i, got_q[gb+i], exp_q[eb+i]); end
      end
    end
  endtask

  task automatic test_random;
    int eb, gb, sofs;
    bit ok;
    eb = exp_q.size(); gb = got_q.size();
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) send_frame(16, 8, 16, 2);
    rdy_mode = 0;
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_drain got out_vld=%b want 0", out_vld); end
    n_checks++;
    if (got_q.size() - gb !== 384) begin n_fail++; $display("FAIL rand_count got %0d want 384", got_q.size() - gb); end
    else begin
      for (int i = 0; i < exp_q.size() - eb; i++) begin
        n_checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin n_fail++; $display("FAIL rand_pix%0d got %h want %h", i, got_q[gb+i], exp_q[eb+i]); end
      end
    end
    sofs = 0;
    for (int i = gb; i < got_q.size(); i++) sofs += int'(got_q[i][24]);
    n_checks++; if (sofs !== 3) begin n_fail++; $display("FAIL rand_sof_count got %0d want 3", sofs); end
    n_checks++; if (aw !== 14'd16 || ah !== 14'd8) begin n_fail++; $display("FAIL rand_geom got %0dx%0d want 16x8", aw, ah); end
    n_checks++; if (fv !== 1'b1) begin n_fail++; $display("FAIL rand_frame_valid got %b want 1", fv); end
  endtask

  initial begin
    test_reset();
    test_midframe();
    test_basic_frame();
    test_backpressure();
    test_line_err();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/svo_dec.md
SVO_DEC -- requirements
Module: svo_dec

Interface
REQ-001 SHALL have parameter SVO_BITS_PER_PIXEL, default 24, pixel data width.
REQ-002 SHALL have parameter SVO_XYBITS, default 14, width of measured-geometry counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_axis_tvalid  input  1  encoded video beat valid.
REQ-006 SHALL have port in_axis_tready  output  1  decoder accepts beat.
REQ-007 SHALL have port in_axis_tdata  input  SVO_BITS_PER_PIXEL  pixel data.
REQ-008 SHALL have port in_axis_tuser  input  4  [0] start of frame, [1] hsync, [2] vsync, [3] blank.
REQ-009 SHALL have port out_axis_tvalid  output  1  active pixel valid.
REQ-010 SHALL have port out_axis_tready  input  1  sink accepts pixel.
REQ-011 SHALL have port out_axis_tdata  output  SVO_BITS_PER_PIXEL  active pixel data.
REQ-012 SHALL have port out_axis_tuser  output  1  [0] first active pixel of frame.
REQ-013 SHALL have port active_width  output  SVO_XYBITS  last measured active pixels per line.
REQ-014 SHALL have port active_height  output  SVO_XYBITS  last measured active lines per frame.
REQ-015 SHALL have port frame_valid  output  1  geometry measured and consistent.
REQ-016 SHALL have port line_err  output  1  one-cycle pulse on line-width mismatch.

Function
REQ-017 SHALL buffer decoded pixels in a 4-entry FIFO of {sof, data}; out_axis_tvalid = FIFO non-empty; out_axis_tdata/tuser = FIFO head; pop on out_axis_tvalid && out_axis_tready.
REQ-018 SHALL drive in_axis_tready = (FIFO fill < 3), derived from registers only; no combinational path from out_axis_tready or in_axis_tuser.
REQ-019 SHALL, on simultaneous push and pop, leave fill unchanged; never overflow or underflow; pointers wrap modulo 4.
REQ-020 SHALL have latency 1: a non-blank beat accepted at edge N is on out_axis_tvalid after edge N when FIFO was empty.
REQ-021 SHALL run FSM SEARCH/ACTIVE; reset enters SEARCH; in SEARCH every accepted beat is discarded except a beat with tuser[0]=1, which moves FSM to ACTIVE and is processed as an ACTIVE beat that same cycle.
REQ-022 SHALL, in ACTIVE, discard accepted beats with tuser[3]=1 and push beats with tuser[3]=0; hsync/vsync bits are ignored for data.
REQ-023 SHALL set pushed sof=1 only on the first non-blank beat after the latest accepted tuser[0]=1 beat; all other pushes sof=0.
REQ-024 SHALL count non-blank beats in the current run (wcnt); the first blank beat after a non-empty run is line end: wcnt -> active_width, hcnt increments, wcnt clears.
REQ-025 SHALL, at line end when hcnt>0 (a prior line this frame exists) and wcnt != active_width, pulse line_err for one cycle and clear frame_valid.
REQ-026 SHALL, on accepted tuser[0]=1 beat in ACTIVE, latch hcnt -> active_height, clear hcnt, and set frame_valid iff no line_err since the previous SOF and hcnt>0; the first SOF (from SEARCH) latches nothing.
REQ-027 SHALL saturate wcnt and hcnt at 2^SVO_XYBITS-1.
REQ-028 SHALL treat a SOF beat that is also non-blank as both frame start and first pixel (wcnt=1 afterwards).
REQ-029 SHALL ignore all input when in_axis_tvalid=0 or in_axis_tready=0; no state changes.

Reset
REQ-030 SHALL, while resetn=0, asynchronously force: FSM SEARCH, FIFO empty, in_axis_tready 0, out_axis_tvalid 0, out_axis_tdata 0, out_axis_tuser 0, active_width 0, active_height 0, frame_valid 0, line_err 0, counters 0.
REQ-031 SHALL, on reset assertion mid-frame, drop buffered pixels; after release, in_axis_tready rises at the first clk edge and decoding restarts at next SOF.

Verification
REQ-032 Frame 4x2 active, 2 blank beats per line, 1 blank line, continuous valid, sink always ready -> 8 pixels out in order, first tuser[0]=1; after 2nd SOF active_width=4, active_height=2, frame_valid=1.
REQ-033 Stream starting mid-frame (5 non-blank beats before SOF) -> zero output before first SOF; first output pixel has tuser[0]=1.
REQ-034 out_axis_tready=0 for 10 cycles -> FIFO fills to 3, in_axis_tready=0, no beat lost or duplicated; release -> order preserved.
REQ-035 Line widths 4,3 in one frame -> line_err single-cycle pulse at second line end; frame_valid=0 at next SOF.
REQ-036 resetn low for 1 cycle mid-line (async, between edges) -> outputs zero immediately; after release no output until next SOF.
REQ-037 Random tvalid/tready toggling over 3 frames of 16x8 -> output sequence equals non-blank input sequence; one tuser[0]=1 per frame.
